// File: rtl/uart_instr_fetch.sv
// uart_instr_fetch: sends {FETCH_CMD, address} over the shared UART and assembles the
// two reply bytes (high byte first) into a 16-bit instruction. Each wait state has a
// reply timeout; a timed-out attempt restarts from the command byte until the retry
// budget is spent, after which err_out pulses and the block returns to idle.
module uart_instr_fetch #(
    parameter logic [7:0]  FETCH_CMD      = 8'h03,
    parameter int unsigned TIMEOUT_CYCLES = 120000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic [7:0]  address,
    input  logic        stop_for_rw,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        tx_done,
    output logic        tx_start_out,
    output logic [7:0]  tx_data_out,
    output logic [15:0] instruction_out,
    output logic        done_out,
    output logic        err_out
);

    // Counter value seen on the last permitted cycle of a wait state.
    localparam logic [16:0] TmoLast  = 17'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  RetryMax = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        StIdle,
        StSendCmd,
        StWaitCmd,
        StSendAddr,
        StWaitAddr,
        StRxHi,
        StRxLo,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [16:0] tmo_q, tmo_d;
    logic [2:0]  retry_q, retry_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] instr_q, instr_d;
    logic        tx_start_q, tx_start_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        waiting;
    logic        expired;
    logic        give_up;

    assign waiting = (state_q == StWaitCmd) || (state_q == StWaitAddr) ||
                     (state_q == StRxHi) || (state_q == StRxLo);
    assign expired = (tmo_q == TmoLast);

    // Next-state logic; outputs are computed for the state being entered so they register
    // in step with it (tx_start_out is high exactly while in a SEND state).
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        retry_d    = retry_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        tx_data_d  = tx_data_q;
        instr_d    = instr_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        give_up    = 1'b0;

        case (state_q)
            StIdle: begin
                if (fetch_en && !stop_for_rw) begin
                    addr_d     = address;
                    retry_d    = '0;
                    state_d    = StSendCmd;
                    tx_start_d = 1'b1;
                    tx_data_d  = FETCH_CMD;
                end
            end
            StSendCmd: state_d = StWaitCmd;
            StWaitCmd: begin
                if (tx_done) begin
                    state_d    = StSendAddr;
                    tx_start_d = 1'b1;
                    tx_data_d  = addr_q;
                end else if (expired) begin
                    give_up = 1'b1;
                end
            end
            StSendAddr: state_d = StWaitAddr;
            StWaitAddr: begin
                if (tx_done) begin
                    state_d = StRxHi;
                end else if (expired) begin
                    give_up = 1'b1;
                end
            end
            StRxHi: begin
                if (rx_done) begin
                    hi_d    = rx_data;
                    state_d = StRxLo;
                end else if (expired) begin
                    give_up = 1'b1;
                end
            end
            StRxLo: begin
                if (rx_done) begin
                    instr_d = {hi_q, rx_data};
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (expired) begin
                    give_up = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Timed out: restart from the command byte while retries remain, else abort.
        if (give_up) begin
            if (retry_q < RetryMax) begin
                retry_d    = retry_q + 3'd1;
                state_d    = StSendCmd;
                tx_start_d = 1'b1;
                tx_data_d  = FETCH_CMD;
            end else begin
                err_d   = 1'b1;
                state_d = StIdle;
            end
        end

        // Counter restarts on every state entry and only runs while waiting.
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (waiting) begin
            tmo_d = tmo_q + 17'd1;
        end
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tmo_q      <= '0;
            retry_q    <= '0;
            addr_q     <= '0;
            hi_q       <= '0;
            tx_data_q  <= '0;
            instr_q    <= '0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            tx_data_q  <= tx_data_d;
            instr_q    <= instr_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx_start_out    = tx_start_q;
    assign tx_data_out     = tx_data_q;
    assign instruction_out = instr_q;
    assign done_out        = done_q;
    assign err_out         = err_q;

endmodule

// File: doc/uart_instr_fetch.md
Name: uart_instr_fetch

Overview:
- Upstream stage of the Bitty core. Each fetch sends a 2-byte request {FETCH_CMD, address} through the shared UART, then assembles the 2-byte reply (high byte first) into a 16-bit instruction for the core and branch logic.
- Owns the UART TX/RX handshakes while the top-level FSM is in its fetch phase.
- Releases the UART to the core when stop_for_rw is high.
- Adds a reply timeout with bounded retries.

Parameters:
- FETCH_CMD, 8'h03, command byte sent before the address.
- TIMEOUT_CYCLES, 120000, clk cycles allowed per wait state before abort/retry (1 to 2^17-1).
- MAX_RETRY, 3, retries after the first attempt before reporting an error (0 to 7).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fetch_en  in  1  level request to fetch the instruction at address
- address  in  8  PC value, sampled when the request is accepted
- stop_for_rw  in  1  UART owned by the core; inhibits the start of a new fetch
- rx_done  in  1  1-cycle pulse: UART received byte valid on rx_data
- rx_data  in  8  received byte
- tx_done  in  1  1-cycle pulse: UART finished sending a byte
- tx_start_out  out  1  1-cycle pulse: send tx_data_out
- tx_data_out  out  8  byte to transmit
- instruction_out  out  16  last fetched instruction
- done_out  out  1  1-cycle pulse on successful fetch
- err_out  out  1  1-cycle pulse when all retries are exhausted

Behaviour:
- Reset (async, active-high): state=IDLE; instruction_out=16'h0000; tx_data_out=8'h00; tx_start_out=0; done_out=0; err_out=0; timeout counter=0; retry counter=0; latched address=0.
- All outputs are registered.
- States and transitions:
  - IDLE: if fetch_en=1 and stop_for_rw=0, latch address, clear retry count, go to SEND_CMD. rx_done/tx_done are ignored in IDLE.
  - SEND_CMD: drive tx_data_out=FETCH_CMD, pulse tx_start_out for exactly 1 cycle, go to WAIT_CMD.
  - WAIT_CMD: on tx_done go to SEND_ADDR.
  - SEND_ADDR: drive tx_data_out=latched address, pulse tx_start_out, go to WAIT_ADDR.
  - WAIT_ADDR: on tx_done go to RX_HI.
  - RX_HI: on rx_done capture rx_data into the internal hi register, go to RX_LO.
  - RX_LO: on rx_done set instruction_out={hi, rx_data} and go to DONE. instruction_out updates in the same edge as the transition.
  - DONE: done_out=1 for this single cycle, then IDLE.
- tx_data_out holds its last value outside SEND states.
- Latency with ideal UART: tx_start_out at cycle 1 after acceptance; done_out one cycle after the final rx_done.
- Timeout:
  - Counter clears on every state entry and increments each cycle in WAIT_CMD, WAIT_ADDR, RX_HI, RX_LO.
  - On reaching TIMEOUT_CYCLES without the awaited pulse: if retry<MAX_RETRY, increment retry and return to SEND_CMD using the latched address; else pulse err_out for 1 cycle and go to IDLE.
  - instruction_out is unchanged on error.
- Stray pulses: an rx_done in WAIT_CMD/WAIT_ADDR is discarded; a tx_done in RX_HI/RX_LO is discarded. An awaited pulse arriving in the same cycle as expiry wins (no retry).
- stop_for_rw is only checked in IDLE. A transaction in progress completes regardless.
- address and fetch_en changes after acceptance have no effect.
- fetch_en held high after DONE starts the next fetch from IDLE on the following cycle, i.e. a minimum one IDLE cycle between fetches.
- Reset asserted mid-transaction aborts immediately to the reset state; no done_out or err_out is produced.

Test Plan:
- address=8'h2A, fetch_en=1; bench answers tx_done 10 cycles after each tx_start, then rx bytes 8'h12, 8'h34 -> tx bytes 03, 2A in order; instruction_out=16'h1234; one done_out pulse.
- TIMEOUT_CYCLES=50, MAX_RETRY=1; no reply on the first attempt, normal reply 8'hAB, 8'hCD on the retry -> two 03/addr pairs sent; instruction_out=16'hABCD; err_out never asserts.
- TIMEOUT_CYCLES=50, MAX_RETRY=2; no tx_done ever -> 3 SEND_CMD pulses, then err_out pulse; instruction_out keeps its previous value; state returns to IDLE.
- stop_for_rw=1 with fetch_en=1 for 20 cycles, with rx_done pulses injected -> no tx_start_out, instruction_out unchanged. Drop stop_for_rw -> fetch starts on the next cycle.
- Assert reset while in RX_LO after hi byte 8'h77 -> all outputs return to reset values immediately. A following fetch returns a fresh value, with no 8'h77 carried over.
- Inject rx_done during WAIT_ADDR, plus a coincident timeout expiry and awaited tx_done -> stray byte ignored; the transition wins; no retry counted.
